// File: rtl/riscv_test_pkg.sv
// Shared types and constants for the riscv-tests pass/fail monitor.
package riscv_test_pkg;

   // Monitor state: RUN until the test terminates or times out; the other
   // three states are terminal and only rst leaves them.
   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_PASS    = 2'd1,
      ST_FAIL    = 2'd2,
      ST_TIMEOUT = 2'd3
   } mon_state_e;

   // Register index of gp (x3), which riscv-tests use to hold the test number.
   localparam logic [4:0]  GP_IDX        = 5'd3;
   // gp value that signals every test passed.
   localparam logic [31:0] GP_PASS_VALUE = 32'd1;

endpackage

// File: rtl/monitor_timeout_ctr.sv
// Enable-gated 32-bit cycle counter with a terminal-count flag at TIMEOUT-1.
module monitor_timeout_ctr #(
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [31:0] count,
   output logic        tc
);

   localparam logic [31:0] TC_VALUE = 32'(TIMEOUT - 1);

   // Count enabled cycles; holds when en is low, clears on rst.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         count <= count + 32'd1;
      end
   end

   assign tc = (count == TC_VALUE);

endmodule

// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout monitor for riscv-tests: shadows gp (x3) from the
// register-file write port and watches the PC for the termination address.
// Optional feature: define MONITOR_ECALL_EN to let a retiring ecall also
// terminate the test.
module riscv_test_monitor
   import riscv_test_pkg::*;
#(
   parameter logic [31:0] PASS_PC = 32'h44,
   parameter int unsigned TIMEOUT = 5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        rf_we_i,
   input  logic [4:0]  rf_waddr_i,
   input  logic [31:0] rf_wdata_i,
   input  logic        ecall_i,
   output logic        done_o,
   output logic        pass_o,
   output logic        fail_o,
   output logic        timeout_o,
   output logic [30:0] test_num_o,
   output logic [31:0] cycle_cnt_o
);

   // Interface timing: there is no handshake. Every input is sampled on each
   // rising edge and only needs to be valid for that one cycle; outputs
   // change only on edges (or asynchronously on rst).

   mon_state_e  state_q, state_d;
   logic [31:0] gp_q;
   logic [30:0] test_num_q;
   logic        term;
   logic        tc;
   logic        cnt_en;

`ifdef MONITOR_ECALL_EN
   assign term = (pc_i == PASS_PC) || ecall_i;
`else
   logic ecall_unused;
   assign ecall_unused = ecall_i;
   assign term = (pc_i == PASS_PC);
`endif

   // Count only while staying in RUN, so the value freezes at the edge that
   // leaves RUN (termination or timeout).
   assign cnt_en = (state_q == ST_RUN) && !term && !tc;

   monitor_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (cnt_en),
      .count (cycle_cnt_o),
      .tc    (tc)
   );

   // gp shadow: follows every write to x3 regardless of monitor state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gp_q <= '0;
      end else if (rf_we_i && (rf_waddr_i == GP_IDX)) begin
         gp_q <= rf_wdata_i;
      end
   end

   // State register and test-number capture at termination.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         test_num_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == ST_RUN) && term) begin
            test_num_q <= gp_q[31:1];
         end
      end
   end

   // Next state: termination uses the registered shadow and wins over timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (term) begin
               state_d = (gp_q == GP_PASS_VALUE) ? ST_PASS : ST_FAIL;
            end else if (tc) begin
               state_d = ST_TIMEOUT;
            end
         end
         default: state_d = state_q;
      endcase
   end

   assign pass_o     = (state_q == ST_PASS);
   assign fail_o     = (state_q == ST_FAIL);
   assign timeout_o  = (state_q == ST_TIMEOUT);
   assign done_o     = pass_o | fail_o | timeout_o;
   assign test_num_o = test_num_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench for riscv_test_monitor with TIMEOUT reduced to 50.
module tb_riscv_test_monitor;

  localparam int unsigned TB_TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_i = '0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_waddr_i = '0;
  logic [31:0] rf_wdata_i = '0;
  logic        ecall_i = 1'b0;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [30:0] test_num_o;
  logic [31:0] cycle_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  riscv_test_monitor #(
    .PASS_PC (32'h44),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_i        (pc_i),
    .rf_we_i     (rf_we_i),
    .rf_waddr_i  (rf_waddr_i),
    .rf_wdata_i  (rf_wdata_i),
    .ecall_i     (ecall_i),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .test_num_o  (test_num_o),
    .cycle_cnt_o (cycle_cnt_o)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_pass, input logic e_fail,
                          input logic e_to, input logic [30:0] e_num, input logic [31:0] e_cnt);
    chk({tag, ".pass"}, {31'd0, pass_o}, {31'd0, e_pass});
    chk({tag, ".fail"}, {31'd0, fail_o}, {31'd0, e_fail});
    chk({tag, ".timeout"}, {31'd0, timeout_o}, {31'd0, e_to});
    chk({tag, ".done"}, {31'd0, done_o}, {31'd0, e_pass | e_fail | e_to});
    chk({tag, ".test_num"}, {1'b0, test_num_o}, {1'b0, e_num});
    chk({tag, ".cycle_cnt"}, cycle_cnt_o, e_cnt);
  endtask

  // advance n edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_i = 32'h0; rf_we_i = 1'b0; rf_waddr_i = 5'd0; rf_wdata_i = 32'd0; ecall_i = 1'b0;
  endtask

  // hold reset across one edge, release just after an edge (cycle 0)
  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    tick(1);
    chk_outs({tag, ".in_reset"}, 0, 0, 0, 31'd0, 32'd0);
    rst = 1'b0;
  endtask

  task automatic rf_write(input logic [4:0] addr, input logic [31:0] data);
    rf_we_i = 1'b1; rf_waddr_i = addr; rf_wdata_i = data;
    tick(1);
    rf_we_i = 1'b0; rf_waddr_i = 5'd0; rf_wdata_i = 32'd0;
  endtask

  task automatic pc_match();
    pc_i = 32'h44;
    tick(1);
    pc_i = 32'h0;
  endtask

  initial begin
    // 1: x3 <- 1 at cycle 10, pc match at cycle 20 -> pass, count frozen at 20
    do_reset("pass");
    chk_outs("pass.start", 0, 0, 0, 31'd0, 32'd0);
    tick(10);
    chk("pass.cnt10", cycle_cnt_o, 32'd10);
    rf_write(5'd3, 32'd1);
    tick(9);
    chk_outs("pass.before", 0, 0, 0, 31'd0, 32'd20);
    pc_match();
    chk_outs("pass.after", 1, 0, 0, 31'd0, 32'd20);
    tick(5);
    chk_outs("pass.frozen", 1, 0, 0, 31'd0, 32'd20);

    // 2: x3 <- 7 then pc match -> fail with test 3
    do_reset("fail7");
    rf_write(5'd3, 32'h7);
    pc_match();
    chk_outs("fail7", 0, 1, 0, 31'd3, 32'd1);

    // 3: no pc match -> timeout after edge 50, count 49 frozen, later match ignored
    do_reset("to");
    tick(49);
    chk_outs("to.edge49", 0, 0, 0, 31'd0, 32'd49);
    tick(1);
    chk_outs("to.edge50", 0, 0, 1, 31'd0, 32'd49);
    rf_write(5'd3, 32'd1);
    pc_match();
    tick(2);
    chk_outs("to.sticky", 0, 0, 1, 31'd0, 32'd49);

    // 4a: shadow 5, then x3 <- 1 on the same edge as pc match -> fail, test 2
    do_reset("same");
    rf_write(5'd3, 32'd5);
    rf_we_i = 1'b1; rf_waddr_i = 5'd3; rf_wdata_i = 32'd1; pc_i = 32'h44;
    tick(1);
    idle_inputs();
    chk_outs("same", 0, 1, 0, 31'd2, 32'd1);

    // 4b: writes to x0 and x4 leave the shadow (5) unchanged
    do_reset("x0");
    rf_write(5'd3, 32'd5);
    rf_write(5'd0, 32'd1);
    rf_write(5'd4, 32'd1);
    pc_match();
    chk_outs("x0", 0, 1, 0, 31'd2, 32'd3);

    // 4c: shadow is cleared by reset: match right away -> fail, test 0
    do_reset("gp0");
    pc_match();
    chk_outs("gp0", 0, 1, 0, 31'd0, 32'd0);

    // 5: async reset at cycle 30, then x3 <- 1 and pc match -> pass
    do_reset("midrst");
    rf_write(5'd3, 32'd1);
    tick(29);
    chk("midrst.cnt30", cycle_cnt_o, 32'd30);
    #2 rst = 1'b1;
    #1;
    chk_outs("midrst.async", 0, 0, 0, 31'd0, 32'd0);
    tick(1);
    rst = 1'b0;
    rf_write(5'd3, 32'd1);
    pc_match();
    chk_outs("midrst.pass", 1, 0, 0, 31'd0, 32'd1);

    // 5b: reset out of a terminal state returns to RUN with cleared outputs
    rst = 1'b1;
    #1;
    chk_outs("termrst", 0, 0, 0, 31'd0, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(3);
    chk_outs("termrst.run", 0, 0, 0, 31'd0, 32'd3);

    // 6: ecall at a non-pass pc with gp == 1
    do_reset("ecall");
    rf_write(5'd3, 32'd1);
    pc_i = 32'h100; ecall_i = 1'b1;
    tick(1);
    idle_inputs();
`ifdef MONITOR_ECALL_EN
    chk_outs("ecall", 1, 0, 0, 31'd0, 32'd1);
    tick(3);
    chk_outs("ecall.frozen", 1, 0, 0, 31'd0, 32'd1);
`else
    chk_outs("ecall", 0, 0, 0, 31'd0, 32'd2);
    tick(3);
    chk_outs("ecall.run", 0, 0, 0, 31'd0, 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable pass/fail monitor that sits beside the core, directly downstream of its PC and register-file write port. Shadows the gp register (x3), detects the riscv-tests termination point, and reports pass, fail with failing test number, or timeout. Replaces ad-hoc bench-side probing of core internals, so every rv32ui test bench checks results the same way.

## Interface
- PASS_PC, 32'h44: PC value that marks test termination
- TIMEOUT, 5000: cycles in RUN before timeout is declared (≥2)
- clk  in  1  system clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- pc_i  in  32  core's current PC
- rf_we_i  in  1  register-file write enable
- rf_waddr_i  in  5  register-file write address
- rf_wdata_i  in  32  register-file write data
- ecall_i  in  1  ecall retiring this cycle
- done_o  out  1  test finished (any outcome), sticky
- pass_o  out  1  gp == 1 at termination, sticky
- fail_o  out  1  gp != 1 at termination, sticky
- timeout_o  out  1  TIMEOUT reached without termination, sticky
- test_num_o  out  31  gp[31:1] captured at termination
- cycle_cnt_o  out  32  cycles spent in RUN

## Operation
- States: RUN, PASS, FAIL, TIMEOUT. Reset enters RUN; PASS/FAIL/TIMEOUT are terminal, left only by rst.
- gp shadow: 32-bit register, reset 0; on each edge with rf_we_i && rf_waddr_i == 3, loads rf_wdata_i. Writes to other addresses, including x0, ignored. Updates continue in every state.
- Termination in RUN: pc_i == PASS_PC. Evaluates the registered shadow value (same-cycle write to x3 not visible). gp == 1 -> PASS; otherwise -> FAIL. test_num_o loads gp[31:1] in both cases.
- Timeout: cycle_cnt_o increments each edge in RUN. On the edge where cycle_cnt_o == TIMEOUT-1 and no termination occurs, enter TIMEOUT.
- Priority on the same edge: termination > timeout.
- cycle_cnt_o freezes in terminal states. Width 32, no wrap possible for legal TIMEOUT.
- Outputs are decoded from the state register. done_o = pass_o | fail_o | timeout_o; at most one of pass_o, fail_o, timeout_o is high.
- rst asserted mid-test: all state, shadow and counters clear immediately; RUN is re-entered on deassertion.

## Timing
- Reset values: done_o, pass_o, fail_o, timeout_o = 0; test_num_o = 0; cycle_cnt_o = 0; state RUN.
- Latency: outputs are high from the edge that samples the termination condition, i.e. visible in the cycle after pc_i == PASS_PC is presented.
- Shadow latency: an x3 write on edge N affects an evaluation on edge N+1 or later.
- No handshake. Inputs are sampled every edge and need no hold beyond one cycle.

## Configuration
- MONITOR_ECALL_EN defined: ecall_i high in RUN also terminates, with the same gp evaluation, test_num_o capture and priority as a PC match. A PC match and ecall on the same edge count as a single termination.
- MONITOR_ECALL_EN undefined: ecall_i is ignored (port kept, unused); only a PC match terminates.

## Structure
- Package riscv_test_pkg: state enum (RUN, PASS, FAIL, TIMEOUT), GP_IDX = 5'd3, GP_PASS_VALUE = 32'd1.
- One sub-module, monitor_timeout_ctr: 32-bit enable-gated counter with terminal-count flag at TIMEOUT-1, clear on rst.

## Test plan
- x3 ← 1 at cycle 10, pc_i = 32'h44 at cycle 20 -> pass_o = done_o = 1 from cycle 21, test_num_o = 0, cycle_cnt_o = 20 frozen.
- x3 ← 32'h7 (test 3 failed), pc_i = 32'h44 -> fail_o = 1, test_num_o = 3, pass_o = 0.
- pc_i never 32'h44, TIMEOUT = 50 -> timeout_o = 1 after edge 50, cycle_cnt_o = 49 frozen; a later pc match changes nothing.
- x3 ← 1 on the same edge pc_i = 32'h44, shadow previously 5 -> fail_o = 1, test_num_o = 2. A separate write of 1 to x0 leaves shadow unchanged.
- rst asserted mid-run at cycle 30, then x3 ← 1 and a pc match -> outputs clear asynchronously, then pass_o = 1 with cycle_cnt_o counted from the deassertion.
- MONITOR_ECALL_EN defined: x3 = 1, ecall_i = 1 at pc 32'h100 -> pass_o = 1. Undefined: same stimulus -> no termination, counter keeps running.
